// File: rtl/ps2_kbd_event_fifo_pkg.sv
// PS/2 keyboard event path: shared constants,
// event type and frame bit positions.
package ps2_pkg;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

  localparam int FRAME_BITS = 11;
  localparam int BIT_START  = 0;
  localparam int BIT_D0     = 1;
  localparam int BIT_D7     = 8;
  localparam int BIT_PAR    = 9;
  localparam int BIT_STOP   = 10;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

  // Start low, odd parity over data+parity, stop high.
  function automatic logic frame_ok(
    input logic [FRAME_BITS-1:0] f
  );
    return !f[BIT_START]
        && (^f[BIT_PAR:BIT_D0])
        && f[BIT_STOP];
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronisers, falling
// edge strobe, 11-bit shifter, checks and timeout.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       err_pulse
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] csync_q;
  logic [SYNC_STAGES-1:0] dsync_q;
  logic                   clk_s;
  logic                   dat_s;
  logic                   clk_prev_q;
  logic                   strobe;

  logic [3:0]            bitcnt_q, bitcnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [FRAME_BITS-1:0] frame_w;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  bv_q, bv_d;
  logic                  err_q, err_d;
  logic [7:0]            byte_q, byte_d;

  assign clk_s  = csync_q[SYNC_STAGES-1];
  assign dat_s  = dsync_q[SYNC_STAGES-1];
  assign strobe = clk_prev_q & ~clk_s;

  // Idle PS/2 lines are high; sync chains reset high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      csync_q    <= '1;
      dsync_q    <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      csync_q    <= {csync_q[SYNC_STAGES-2:0], ps2_clk};
      dsync_q    <= {dsync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q <= clk_s;
    end
  end

  // Shift a bit per strobe; check on the 11th; time out.
  always_comb begin
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    tmo_d    = tmo_q;
    bv_d     = 1'b0;
    err_d    = 1'b0;
    byte_d   = byte_q;
    frame_w  = {dat_s, shift_q[FRAME_BITS-1:1]};
    if (strobe) begin
      shift_d = frame_w;
      tmo_d   = '0;
      if (bitcnt_q == 4'(FRAME_BITS - 1)) begin
        bitcnt_d = '0;
        if (frame_ok(frame_w)) begin
          bv_d   = 1'b1;
          byte_d = frame_w[BIT_D7:BIT_D0];
        end else begin
          err_d = 1'b1;
        end
      end else begin
        bitcnt_d = bitcnt_q + 4'd1;
      end
    end else if (bitcnt_q != '0) begin
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        bitcnt_d = '0;
        tmo_d    = '0;
        err_d    = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      tmo_d = '0;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bitcnt_q <= '0;
      shift_q  <= '0;
      tmo_q    <= '0;
      bv_q     <= 1'b0;
      err_q    <= 1'b0;
      byte_q   <= '0;
    end else begin
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      tmo_q    <= tmo_d;
      bv_q     <= bv_d;
      err_q    <= err_d;
      byte_q   <= byte_d;
    end
  end

  assign byte_valid = bv_q;
  assign rx_byte    = byte_q;
  assign err_pulse  = err_q;

endmodule

// File: rtl/ps2_kbd_event_fifo.sv
// PS/2 keyboard front end: prefix folding, repeat
// filter and a first-word-fall-through event FIFO.
module ps2_kbd_event_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH      = 8,
  parameter int SYNC_STAGES     = 3,
  parameter int TIMEOUT_CYCLES  = 50000,
  parameter int CNT_W           = 8,
  parameter int SUPPRESS_REPEAT = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  input  logic             rd_en,
  input  logic             clr_err,
  output logic             ev_valid,
  output logic [7:0]       ev_code,
  output logic             ev_break,
  output logic             ev_ext,
  output logic             fifo_full,
  output logic             overflow,
  output logic             frame_err,
  output logic [CNT_W-1:0] press_count,
  output logic             key_held
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic       byte_valid;
  logic [7:0] rx_byte;
  logic       err_pulse;

  logic             ext_pend_q, ext_pend_d;
  logic             brk_pend_q, brk_pend_d;
  logic             held_v_q, held_v_d;
  logic             held_ext_q, held_ext_d;
  logic [7:0]       held_code_q, held_code_d;
  logic [CNT_W-1:0] press_q, press_d;
  logic             match;
  logic             push;
  ps2_event_t       evt;

  ps2_event_t     mem_q [FIFO_DEPTH];
  ps2_event_t     head;
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    occ_q;
  logic           pop, full, wr_ok, ovf_evt;
  logic           ovf_q, ferr_q;

  ps2_frame_rx #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .resetn    (resetn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_valid(byte_valid),
    .rx_byte   (rx_byte),
    .err_pulse (err_pulse)
  );

  // Fold prefixes into one event and drop held-key repeats.
  always_comb begin
    ext_pend_d  = ext_pend_q;
    brk_pend_d  = brk_pend_q;
    held_v_d    = held_v_q;
    held_ext_d  = held_ext_q;
    held_code_d = held_code_q;
    press_d     = press_q;
    push        = 1'b0;
    evt         = '{ext: ext_pend_q,
                    brk: brk_pend_q,
                    code: rx_byte};
    match       = held_v_q
               && (held_ext_q == ext_pend_q)
               && (held_code_q == rx_byte);
    if (byte_valid) begin
      unique case (1'b1)
        (rx_byte == PS2_PFX_EXT): ext_pend_d = 1'b1;
        (rx_byte == PS2_PFX_BRK): brk_pend_d = 1'b1;
        default: begin
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
          if (brk_pend_q) begin
            push = 1'b1;
            if (match) held_v_d = 1'b0;
          end else if (!((SUPPRESS_REPEAT != 0) && match)) begin
            push        = 1'b1;
            held_v_d    = 1'b1;
            held_ext_d  = ext_pend_q;
            held_code_d = rx_byte;
            press_d     = press_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  // Decoder and filter state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
      held_v_q    <= 1'b0;
      held_ext_q  <= 1'b0;
      held_code_q <= '0;
      press_q     <= '0;
    end else begin
      ext_pend_q  <= ext_pend_d;
      brk_pend_q  <= brk_pend_d;
      held_v_q    <= held_v_d;
      held_ext_q  <= held_ext_d;
      held_code_q <= held_code_d;
      press_q     <= press_d;
    end
  end

  assign pop     = rd_en && (occ_q != '0);
  assign full    = (occ_q == (AW+1)'(FIFO_DEPTH));
  assign wr_ok   = push && (!full || pop);
  assign ovf_evt = push && full && !pop;

  // Event storage; no reset needed, reads gated by occupancy.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= evt;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_ok, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Sticky error flags; a new error beats clr_err.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ovf_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      if (ovf_evt)      ovf_q <= 1'b1;
      else if (clr_err) ovf_q <= 1'b0;
      if (err_pulse)    ferr_q <= 1'b1;
      else if (clr_err) ferr_q <= 1'b0;
    end
  end

  assign head        = mem_q[rd_ptr_q];
  assign ev_valid    = (occ_q != '0);
  assign ev_code     = ev_valid ? head.code : 8'h00;
  assign ev_break    = ev_valid & head.brk;
  assign ev_ext      = ev_valid & head.ext;
  assign fifo_full   = full;
  assign overflow    = ovf_q;
  assign frame_err   = ferr_q;
  assign press_count = press_q;
  assign key_held    = held_v_q;

endmodule

// File: tb/tb_ps2_kbd_event_fifo.sv
// Scoreboard bench: directed PS/2 frames in, expected
// events queued, a monitor pops and compares on reads.
module tb_ps2_kbd_event_fifo;

  localparam int H   = 8;
  localparam int TMO = 200;

  logic       clk;
  logic       resetn;
  logic       ps2_clk;
  logic       ps2_data;
  logic       rd_en;
  logic       clr_err;
  logic       rd_one;

  logic       ev_valid, ev_break, ev_ext;
  logic [7:0] ev_code;
  logic       fifo_full, overflow, frame_err, key_held;
  logic [7:0] press_count;

  logic       u1_valid, u1_break, u1_ext;
  logic [7:0] u1_code;
  logic       u1_full, u1_ovf, u1_ferr, u1_held;
  logic [7:0] u1_press;

  int         vectors = 0;
  int         miscompares = 0;
  int         u1_events = 0;
  logic [9:0] exp_q[$];
  logic [9:0] mon_e;

  ps2_kbd_event_fifo #(
    .FIFO_DEPTH(8), .SYNC_STAGES(3),
    .TIMEOUT_CYCLES(TMO), .CNT_W(8),
    .SUPPRESS_REPEAT(1)
  ) u0 (
    .clk(clk), .resetn(resetn),
    .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd_en(rd_en), .clr_err(clr_err),
    .ev_valid(ev_valid), .ev_code(ev_code),
    .ev_break(ev_break), .ev_ext(ev_ext),
    .fifo_full(fifo_full), .overflow(overflow),
    .frame_err(frame_err),
    .press_count(press_count),
    .key_held(key_held)
  );

  ps2_kbd_event_fifo #(
    .FIFO_DEPTH(8), .SYNC_STAGES(3),
    .TIMEOUT_CYCLES(TMO), .CNT_W(8),
    .SUPPRESS_REPEAT(0)
  ) u1 (
    .clk(clk), .resetn(resetn),
    .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd_en(rd_one), .clr_err(clr_err),
    .ev_valid(u1_valid), .ev_code(u1_code),
    .ev_break(u1_break), .ev_ext(u1_ext),
    .fifo_full(u1_full), .overflow(u1_ovf),
    .frame_err(u1_ferr),
    .press_count(u1_press),
    .key_held(u1_held)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Scoreboard monitor: every read of a valid head.
  always @(negedge clk) begin
    if (resetn && rd_en && ev_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL event_unexpected: got %h",
                 {ev_ext, ev_break, ev_code});
      end else begin
        mon_e = exp_q.pop_front();
        if ({ev_ext, ev_break, ev_code} !== mon_e) begin
          miscompares++;
          $display("FAIL event: got %h expected %h",
                   {ev_ext, ev_break, ev_code}, mon_e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (resetn && u1_valid) u1_events++;
  end

  task automatic send_frame(input logic [7:0] b,
                            input bit flip,
                            input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk); #1 ps2_data = f[i];
      repeat (H) @(posedge clk);
      #1 ps2_clk = 1'b0;
      repeat (H) @(posedge clk);
      #1 ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic settle();
    repeat (10) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(posedge clk); #1 rd_en = 1'b1;
    forever begin
      @(negedge clk);
      if (!ev_valid) break;
      n++;
      if (n > 40) begin
        vectors++;
        miscompares++;
        $display("FAIL drain_bound: got %0d expected 0",
                 n);
        break;
      end
    end
    rd_en = 1'b0;
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
    @(negedge clk);
  endtask

  logic [7:0] codes [9];
  int         e0;
  logic [7:0] p0;

  initial begin
    codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,
              8'h35, 8'h3C, 8'h43, 8'h44};
    rd_one   = 1'b1;
    resetn   = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    rd_en    = 1'b0;
    clr_err  = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("reset_outs",
          {ev_valid, ev_code, ev_break, ev_ext,
           fifo_full, overflow, frame_err,
           press_count, key_held}, 0);
    resetn = 1'b1;

    // make, break of one key
    send_frame(8'h1C, 0, 11);
    exp_q.push_back({2'b00, 8'h1C});
    settle();
    check("t1_held_mid", key_held, 1);
    send_frame(8'hF0, 0, 11);
    send_frame(8'h1C, 0, 11);
    exp_q.push_back({2'b01, 8'h1C});
    settle();
    check("t1_press", press_count, 1);
    check("t1_held", key_held, 0);
    check("t1_head", {ev_ext, ev_break, ev_code},
          {2'b00, 8'h1C});
    drain();

    // typematic repeat
    e0 = u1_events;
    p0 = u1_press;
    for (int i = 0; i < 5; i++) send_frame(8'h1C, 0, 11);
    exp_q.push_back({2'b00, 8'h1C});
    send_frame(8'hF0, 0, 11);
    send_frame(8'h1C, 0, 11);
    exp_q.push_back({2'b01, 8'h1C});
    settle();
    check("t2_press", press_count, 2);
    check("t2_u1_events", u1_events - e0, 6);
    check("t2_u1_press", 8'(u1_press - p0), 5);
    drain();

    // extended keys
    send_frame(8'hE0, 0, 11);
    send_frame(8'h75, 0, 11);
    exp_q.push_back({2'b10, 8'h75});
    send_frame(8'hE0, 0, 11);
    send_frame(8'hF0, 0, 11);
    send_frame(8'h75, 0, 11);
    exp_q.push_back({2'b11, 8'h75});
    settle();
    check("t3_press", press_count, 3);
    check("t3_held", key_held, 0);
    drain();

    // parity error
    send_frame(8'h1C, 1, 11);
    settle();
    check("t4_ferr", frame_err, 1);
    check("t4_empty", ev_valid, 0);
    send_frame(8'h32, 0, 11);
    exp_q.push_back({2'b00, 8'h32});
    settle();
    check("t4_press", press_count, 4);
    check("t4_ovf", overflow, 0);
    pulse_clr();
    check("t4_ferr_clr", frame_err, 0);
    drain();

    // overflow, then pop on a push cycle
    for (int i = 0; i < 9; i++) begin
      send_frame(codes[i], 0, 11);
      if (i < 8) exp_q.push_back({2'b00, codes[i]});
    end
    settle();
    check("t5_full", fifo_full, 1);
    check("t5_ovf", overflow, 1);
    check("t5_press", press_count, 13);
    pulse_clr();
    check("t5_ovf_clr", overflow, 0);
    exp_q.push_back({2'b00, 8'h4B});
    fork
      send_frame(8'h4B, 0, 11);
      begin
        repeat (10 * (2 * H + 1) + 1 + H + 4)
          @(posedge clk);
        #1 rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
      end
    join
    settle();
    check("t5_full_pp", fifo_full, 1);
    check("t5_ovf_pp", overflow, 0);
    check("t5_press_pp", press_count, 14);
    drain();

    // timeout, then a good frame
    send_frame(8'h55, 0, 5);
    repeat (TMO + 20) @(posedge clk);
    @(negedge clk);
    check("t6_tmo_ferr", frame_err, 1);
    check("t6_tmo_empty", ev_valid, 0);
    send_frame(8'h1C, 0, 11);
    exp_q.push_back({2'b00, 8'h1C});
    settle();
    check("t6_press", press_count, 15);
    drain();

    // async reset mid-frame
    send_frame(8'h5A, 0, 11);
    settle();
    check("t6_pre_rst", ev_valid, 1);
    send_frame(8'h29, 0, 3);
    @(posedge clk); #3 resetn = 1'b0;
    #1;
    check("t6_rst_outs",
          {ev_valid, ev_code, ev_break, ev_ext,
           fifo_full, overflow, frame_err,
           press_count, key_held}, 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    send_frame(8'h1C, 0, 11);
    exp_q.push_back({2'b00, 8'h1C});
    settle();
    check("t6_post_press", press_count, 1);
    check("t6_post_held", key_held, 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
